// File: rtl/opl2_pkg.sv
// Shared types, constants and small helpers for the OPL2 operator pipeline.
package opl2_pkg;

  localparam int NUM_OPERATORS     = 18;
  localparam int ENV_WIDTH         = 9;
  localparam int ENV_COUNTER_WIDTH = 15;
  localparam logic [ENV_WIDTH-1:0] ENV_MAX = 9'd511;

  typedef enum logic [1:0] {
    ATTACK  = 2'd0,
    DECAY   = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  // Per-slot request captured at p0 and carried into the p1 update.
  typedef struct packed {
    logic       sample;
    logic [4:0] op;
    logic       key;
    logic [3:0] ar;
    logic [3:0] dr;
    logic [3:0] rr;
    logic [3:0] sl;
    logic [5:0] tl;
    logic       egt;
    logic       am;
    logic       ksr;
    logic [3:0] ks;
    logic [3:0] trem;
  } env_slot_t;

  // Unscaled key-scale code; the ksr shift is applied where the rate is formed.
  function automatic logic [3:0] key_scale(input logic [2:0] block,
                                           input logic [1:0] fnum_msb,
                                           input logic       nts);
    return {block, (nts ? fnum_msb[0] : fnum_msb[1])};
  endfunction

  function automatic logic [ENV_WIDTH-1:0] sat_add(input logic [ENV_WIDTH-1:0] level,
                                                   input logic [3:0]           inc);
    logic [ENV_WIDTH:0] sum;
    sum = {1'b0, level} + {{(ENV_WIDTH-3){1'b0}}, inc};
    return sum[ENV_WIDTH] ? ENV_MAX : sum[ENV_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/env_rate_step.sv
// Maps a rate register, key scale and the global envelope counter to the per-update step.
module env_rate_step
  import opl2_pkg::*;
(
  input  logic [3:0]                   rate_reg_i,
  input  logic [3:0]                   ks_i,
  input  logic                         ksr_i,
  input  logic [ENV_COUNTER_WIDTH-1:0] env_counter_i,
  output logic [3:0]                   rate_hi_o,
  output logic [3:0]                   inc_o
);

  logic [3:0]                   ks_eff;
  logic [6:0]                   rate_sum;
  logic [5:0]                   rate;
  logic [3:0]                   rate_hi;
  logic [3:0]                   shamt;
  logic [ENV_COUNTER_WIDTH-1:0] mask;
  logic [3:0]                   inc;
  logic                         rate_lsb_unused;

  always_comb begin
    ks_eff   = ksr_i ? ks_i : (ks_i >> 2);
    rate_sum = {1'b0, rate_reg_i, 2'b00} + {3'b000, ks_eff};
    rate     = '0;
    if (rate_reg_i != 4'd0) begin
      rate = (rate_sum > 7'd63) ? 6'd63 : rate_sum[5:0];
    end
    rate_hi = rate[5:2];
    shamt   = '0;
    mask    = '0;
    inc     = '0;
    // Slow rates step on a power-of-two division of the counter; fast rates step every sample.
    if (rate_reg_i != 4'd0) begin
      if (rate_hi <= 4'd12) begin
        shamt = 4'd13 - rate_hi;
        mask  = (ENV_COUNTER_WIDTH'(1) << shamt) - ENV_COUNTER_WIDTH'(1);
        inc   = ((env_counter_i & mask) == '0) ? 4'd1 : 4'd0;
      end else begin
        inc = 4'd1 << (rate_hi - 4'd12);
      end
    end
  end

  assign rate_lsb_unused = ^rate[1:0];
  assign rate_hi_o       = rate_hi;
  assign inc_o           = inc;

endmodule

// File: rtl/env_gen.sv
// Time-multiplexed OPL2 envelope generator: per-slot ADSR update at p1,
// attenuation sum with TL/KSL/tremolo at p2, registered result at p3.
module env_gen
  import opl2_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_clk_en,
  input  logic                 slot_en_p0,
  input  logic [4:0]           op_num_p0,
  input  logic                 key_on_p0,
  input  logic [3:0]           ar_p0,
  input  logic [3:0]           dr_p0,
  input  logic [3:0]           rr_p0,
  input  logic [3:0]           sl_p0,
  input  logic [5:0]           tl_p0,
  input  logic                 ksr_p0,
  input  logic                 egt_p0,
  input  logic                 am_p0,
  input  logic [2:0]           block_p0,
  input  logic [1:0]           fnum_msb_p0,
  input  logic                 nts,
  input  logic [3:0]           trem_p0,
  input  logic [7:0]           ksl_add_p2,
  output logic [ENV_WIDTH-1:0] env_p3,
  output logic                 env_valid_p3
);

  // Valid bits travel with each slot p0->p1->p2->p3; there is no backpressure,
  // a slot is accepted whenever slot_en_p0 is high and reset squashes every stage.

  logic [ENV_COUNTER_WIDTH-1:0] env_counter_q, env_counter_d;

  env_slot_t slot_p0;
  env_slot_t slot_p1_q;
  logic      valid_p1_q;

  env_state_t               state_mem_q [NUM_OPERATORS];
  logic [ENV_WIDTH-1:0]     level_mem_q [NUM_OPERATORS];
  logic [NUM_OPERATORS-1:0] last_key_q;

  logic                 op_ok_p1;
  env_state_t           cur_state, state_d;
  logic [ENV_WIDTH-1:0] cur_level, level_d;
  logic                 cur_key, key_rise, key_fall;
  logic [3:0]           rate_sel;
  logic [3:0]           rate_hi;
  logic [3:0]           inc_raw, inc;
  logic [4:0]           sl_thr;
  logic [10:0]          att_step;
  logic [ENV_WIDTH-1:0] level_up;

  logic                 valid_p2_q;
  logic [ENV_WIDTH-1:0] level_p2_q;
  logic [5:0]           tl_p2_q;
  logic                 am_p2_q;
  logic [3:0]           trem_p2_q;
  logic [10:0]          sum_p2;
  logic [ENV_WIDTH-1:0] env_d;

  logic [ENV_WIDTH-1:0] env_p3_q;
  logic                 valid_p3_q;

  assign env_counter_d = sample_clk_en ? env_counter_q + 1'b1 : env_counter_q;

  always_comb begin
    slot_p0        = '0;
    slot_p0.sample = sample_clk_en;
    slot_p0.op     = op_num_p0;
    slot_p0.key    = key_on_p0;
    slot_p0.ar     = ar_p0;
    slot_p0.dr     = dr_p0;
    slot_p0.rr     = rr_p0;
    slot_p0.sl     = sl_p0;
    slot_p0.tl     = tl_p0;
    slot_p0.egt    = egt_p0;
    slot_p0.am     = am_p0;
    slot_p0.ksr    = ksr_p0;
    slot_p0.ks     = key_scale(block_p0, fnum_msb_p0, nts);
    slot_p0.trem   = trem_p0;
  end

  // p1 read. The memory is written at the end of p1, so a slot presented on the
  // very next cycle already reads the updated entry without extra forwarding.
  always_comb begin
    op_ok_p1  = (slot_p1_q.op < 5'(NUM_OPERATORS));
    cur_state = RELEASE;
    cur_level = ENV_MAX;
    cur_key   = 1'b0;
    if (op_ok_p1) begin
      cur_state = state_mem_q[slot_p1_q.op];
      cur_level = level_mem_q[slot_p1_q.op];
      cur_key   = last_key_q[slot_p1_q.op];
    end
    key_rise = slot_p1_q.key & ~cur_key;
    key_fall = ~slot_p1_q.key & cur_key;
  end

  always_comb begin
    rate_sel = slot_p1_q.rr;
    if (key_rise) begin
      rate_sel = slot_p1_q.ar;
    end else begin
      case (cur_state)
        ATTACK:  rate_sel = slot_p1_q.ar;
        DECAY:   rate_sel = slot_p1_q.dr;
        default: rate_sel = slot_p1_q.rr;
      endcase
    end
  end

  env_rate_step u_rate_step_p1 (
    .rate_reg_i    (rate_sel),
    .ks_i          (slot_p1_q.ks),
    .ksr_i         (slot_p1_q.ksr),
    .env_counter_i (env_counter_q),
    .rate_hi_o     (rate_hi),
    .inc_o         (inc_raw)
  );

  // Level only moves on sample-qualified slot cycles; key edges are always honoured.
  assign inc = slot_p1_q.sample ? inc_raw : 4'd0;

  always_comb begin
    state_d  = cur_state;
    level_d  = cur_level;
    sl_thr   = (slot_p1_q.sl == 4'd15) ? 5'd31 : {1'b0, slot_p1_q.sl};
    att_step = ({5'd0, cur_level[ENV_WIDTH-1:3]} + 11'd1) * {7'd0, inc};
    level_up = sat_add(cur_level, inc);
    if (key_rise) begin
      state_d = ATTACK;
      if (rate_hi == 4'd15) begin
        level_d = '0;
        state_d = DECAY;
      end
    end else if (key_fall) begin
      state_d = RELEASE;
    end else begin
      case (cur_state)
        ATTACK: begin
          if (att_step >= {2'b00, cur_level}) begin
            level_d = '0;
            state_d = DECAY;
          end else begin
            level_d = cur_level - att_step[ENV_WIDTH-1:0];
          end
        end
        DECAY: begin
          level_d = level_up;
          if (level_up[ENV_WIDTH-1:4] >= sl_thr) begin
            state_d = SUSTAIN;
          end
        end
        SUSTAIN: begin
          if (!slot_p1_q.egt) begin
            level_d = level_up;
          end
        end
        default: level_d = level_up;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OPERATORS; i++) begin
        state_mem_q[i] <= RELEASE;
        level_mem_q[i] <= ENV_MAX;
      end
      last_key_q <= '0;
    end else if (valid_p1_q && op_ok_p1) begin
      state_mem_q[slot_p1_q.op] <= state_d;
      level_mem_q[slot_p1_q.op] <= level_d;
      last_key_q[slot_p1_q.op]  <= slot_p1_q.key;
    end
  end

  // p2: fold in TL, KSL (arriving this cycle) and tremolo at 11 bits, then clamp.
  always_comb begin
    sum_p2 = {2'b00, level_p2_q}
           + {3'b000, tl_p2_q, 2'b00}
           + {3'b000, ksl_add_p2}
           + (am_p2_q ? {7'd0, trem_p2_q} : 11'd0);
    env_d  = (sum_p2 > {2'b00, ENV_MAX}) ? ENV_MAX : sum_p2[ENV_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      env_counter_q <= '0;
      slot_p1_q     <= '0;
      valid_p1_q    <= 1'b0;
      valid_p2_q    <= 1'b0;
      level_p2_q    <= ENV_MAX;
      tl_p2_q       <= '0;
      am_p2_q       <= 1'b0;
      trem_p2_q     <= '0;
      env_p3_q      <= ENV_MAX;
      valid_p3_q    <= 1'b0;
    end else begin
      env_counter_q <= env_counter_d;
      slot_p1_q     <= slot_p0;
      valid_p1_q    <= slot_en_p0;
      valid_p2_q    <= valid_p1_q;
      level_p2_q    <= level_d;
      tl_p2_q       <= slot_p1_q.tl;
      am_p2_q       <= slot_p1_q.am;
      trem_p2_q     <= slot_p1_q.trem;
      valid_p3_q    <= valid_p2_q;
      if (valid_p2_q) begin
        env_p3_q <= env_d;
      end
    end
  end

  assign env_p3       = env_p3_q;
  assign env_valid_p3 = valid_p3_q;

endmodule

// File: tb/tb_env_gen.sv
// Directed bench for env_gen: a behavioural slot model fills an expected queue
// at drive time; a monitor pops and checks value and p0->p3 latency.
module tb_env_gen;
  localparam int ST_ATTACK  = 0;
  localparam int ST_DECAY   = 1;
  localparam int ST_SUSTAIN = 2;
  localparam int ST_RELEASE = 3;

  logic       clk;
  logic       reset;
  logic       sample_clk_en;
  logic       slot_en_p0;
  logic [4:0] op_num_p0;
  logic       key_on_p0;
  logic [3:0] ar_p0, dr_p0, rr_p0, sl_p0;
  logic [5:0] tl_p0;
  logic       ksr_p0, egt_p0, am_p0;
  logic [2:0] block_p0;
  logic [1:0] fnum_msb_p0;
  logic       nts;
  logic [3:0] trem_p0;
  logic [7:0] ksl_add_p2;
  logic [8:0] env_p3;
  logic       env_valid_p3;

  env_gen dut (
    .clk           (clk),
    .reset         (reset),
    .sample_clk_en (sample_clk_en),
    .slot_en_p0    (slot_en_p0),
    .op_num_p0     (op_num_p0),
    .key_on_p0     (key_on_p0),
    .ar_p0         (ar_p0),
    .dr_p0         (dr_p0),
    .rr_p0         (rr_p0),
    .sl_p0         (sl_p0),
    .tl_p0         (tl_p0),
    .ksr_p0        (ksr_p0),
    .egt_p0        (egt_p0),
    .am_p0         (am_p0),
    .block_p0      (block_p0),
    .fnum_msb_p0   (fnum_msb_p0),
    .nts           (nts),
    .trem_p0       (trem_p0),
    .ksl_add_p2    (ksl_add_p2),
    .env_p3        (env_p3),
    .env_valid_p3  (env_valid_p3)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d want=finish", cyc);
    $fatal(1, "timeout");
  end

  // scoreboard state
  logic [40:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // model state
  int   m_state [18];
  int   m_level [18];
  bit   m_key   [18];
  int   cnt;
  logic [2:0] g_block;
  logic [1:0] g_fnum;
  logic       g_ksr;
  logic       g_nts;
  logic [7:0] kp0, kp1;

  task automatic model_reset();
    for (int i = 0; i < 18; i++) begin
      m_state[i] = ST_RELEASE;
      m_level[i] = 511;
      m_key[i]   = 1'b0;
    end
    cnt = 0;
  endtask

  function automatic int rate_hi_of(input int r, input int ks);
    int rate;
    if (r == 0) return 0;
    rate = 4 * r + ks;
    if (rate > 63) rate = 63;
    return rate / 4;
  endfunction

  function automatic int inc_of(input int r, input int ks);
    int rh;
    if (r == 0) return 0;
    rh = rate_hi_of(r, ks);
    if (rh >= 13) return 1 << (rh - 12);
    return ((cnt % (1 << (13 - rh))) == 0) ? 1 : 0;
  endfunction

  function automatic int sat511(input int v);
    return (v > 511) ? 511 : v;
  endfunction

  function automatic int model_step(input int op, input bit key, input int ar, dr, rr, sl, tl,
                                    input bit egt, input bit am, input int trem, input int ksl);
    int ks, lv, st, thr, sum;
    ks = g_block * 2 + (g_nts ? g_fnum[0] : g_fnum[1]);
    if (!g_ksr) ks = ks / 4;
    lv = m_level[op];
    st = m_state[op];
    if (key && !m_key[op]) begin
      st = ST_ATTACK;
      if (rate_hi_of(ar, ks) == 15) begin
        lv = 0;
        st = ST_DECAY;
      end
    end else if (!key && m_key[op]) begin
      st = ST_RELEASE;
    end else begin
      case (st)
        ST_ATTACK: begin
          lv = lv - (lv / 8 + 1) * inc_of(ar, ks);
          if (lv <= 0) begin
            lv = 0;
            st = ST_DECAY;
          end
        end
        ST_DECAY: begin
          lv  = sat511(lv + inc_of(dr, ks));
          thr = (sl == 15) ? 31 : sl;
          if (lv / 16 >= thr) st = ST_SUSTAIN;
        end
        ST_SUSTAIN: if (!egt) lv = sat511(lv + inc_of(rr, ks));
        default:    lv = sat511(lv + inc_of(rr, ks));
      endcase
    end
    m_key[op]   = key;
    m_level[op] = lv;
    m_state[op] = st;
    sum = lv + tl * 4 + ksl + (am ? trem : 0);
    return sat511(sum);
  endfunction

  // driver tasks
  task automatic shift_ksl(input int k);
    ksl_add_p2 = kp1;
    kp1        = kp0;
    kp0        = 8'(k);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      slot_en_p0    = 1'b0;
      sample_clk_en = 1'b0;
      shift_ksl(0);
    end
  endtask

  task automatic present(input int op, input bit key, input int ar, dr, rr, sl, tl,
                         input bit egt, input bit am, input int trem, input int ksl);
    int want;
    @(negedge clk);
    slot_en_p0    = 1'b1;
    sample_clk_en = 1'b1;
    op_num_p0     = 5'(op);
    key_on_p0     = key;
    ar_p0         = 4'(ar);
    dr_p0         = 4'(dr);
    rr_p0         = 4'(rr);
    sl_p0         = 4'(sl);
    tl_p0         = 6'(tl);
    egt_p0        = egt;
    am_p0         = am;
    trem_p0       = 4'(trem);
    ksr_p0        = g_ksr;
    block_p0      = g_block;
    fnum_msb_p0   = g_fnum;
    nts           = g_nts;
    shift_ksl(ksl);
    cnt  = (cnt + 1) % 32768;
    want = model_step(op, key, ar, dr, rr, sl, tl, egt, am, trem, ksl);
    exp_q.push_back({32'(cyc + 3), 9'(want)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    slot_en_p0    = 1'b0;
    sample_clk_en = 1'b0;
    shift_ksl(0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    shift_ksl(0);
    total++;
    assert (env_p3 === 9'd511) else begin
      bad++;
      $error("FAIL reset_env got=%0d want=511", env_p3);
    end
    total++;
    assert (env_valid_p3 === 1'b0) else begin
      bad++;
      $error("FAIL reset_valid got=%0b want=0", env_valid_p3);
    end
  endtask

  // scoreboard monitor, sampling 2 time units after the active edge
  always @(posedge clk) begin
    logic [40:0] e;
    #2;
    if (!reset) begin
      if (env_valid_p3 === 1'b1) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_valid cyc=%0d got=%0d want=none", cyc, env_p3);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          total++;
          assert (cyc === int'(e[40:9])) else begin
            bad++;
            $error("FAIL latency got_cyc=%0d want_cyc=%0d", cyc, e[40:9]);
          end
          total++;
          assert (env_p3 === e[8:0]) else begin
            bad++;
            $error("FAIL env cyc=%0d got=%0d want=%0d", cyc, env_p3, e[8:0]);
          end
        end
      end else if (exp_q.size() != 0 && int'(exp_q[0][40:9]) <= cyc) begin
        e = exp_q.pop_front();
        total++;
        assert (env_valid_p3 === 1'b1) else begin
          bad++;
          $error("FAIL missing_valid cyc=%0d got=%0b want=1 env=%0d", cyc, env_valid_p3, e[8:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; sample_clk_en = 1'b0; slot_en_p0 = 1'b0; op_num_p0 = '0; key_on_p0 = 1'b0;
    ar_p0 = '0; dr_p0 = '0; rr_p0 = '0; sl_p0 = '0; tl_p0 = '0; ksr_p0 = 1'b0; egt_p0 = 1'b0;
    am_p0 = 1'b0; block_p0 = '0; fnum_msb_p0 = '0; nts = 1'b0; trem_p0 = '0; ksl_add_p2 = '0;
    kp0 = '0; kp1 = '0;
    g_block = 3'd7; g_fnum = 2'b00; g_ksr = 1'b0; g_nts = 1'b0;
    model_reset();
    do_reset();

    // every slot silent after reset
    for (int s = 0; s < 18; s++) present(s, 0, 15, 15, 15, 0, 0, 0, 0, 0, 0);
    idle(2);

    // slot 0: instant attack, decay to SL=4 (64), hold with egt=1
    present(0, 1, 15, 15, 15, 4, 0, 1, 0, 0, 0);
    repeat (10) present(0, 1, 15, 15, 15, 4, 0, 1, 0, 0, 0);
    // key off, release +8 per sample up to saturation
    repeat (61) present(0, 0, 15, 15, 15, 4, 0, 1, 0, 0, 0);
    idle(3);

    // slot 1: attack to 0, release to 400, then clamp case
    present(1, 1, 15, 15, 15, 0, 0, 0, 0, 0, 0);
    repeat (50) present(1, 0, 15, 15, 15, 0, 0, 0, 0, 0, 0);
    present(1, 0, 15, 15, 15, 0, 63, 0, 1, 13, 96);
    // slot 2: level 0 with TL=10, KSL=16, tremolo disabled
    present(2, 1, 15, 15, 15, 0, 10, 0, 0, 13, 16);
    idle(2);

    // moderate rates with block 0
    g_block = 3'd0;
    present(4, 1, 15, 13, 15, 15, 0, 0, 0, 0, 0);
    repeat (5) present(4, 1, 15, 13, 15, 15, 0, 0, 0, 0, 0);
    present(5, 1, 15, 10, 15, 15, 0, 0, 0, 0, 0);
    repeat (16) present(5, 1, 15, 10, 15, 15, 0, 0, 0, 0, 0);
    present(7, 1, 13, 15, 15, 15, 0, 0, 0, 0, 0);
    repeat (20) present(7, 1, 13, 15, 15, 15, 0, 0, 0, 0, 0);

    // key-scale-rate on and off
    g_block = 3'd3; g_fnum = 2'b10; g_ksr = 1'b1;
    present(6, 1, 15, 11, 15, 15, 0, 0, 0, 0, 0);
    repeat (8) present(6, 1, 15, 11, 15, 15, 0, 0, 0, 0, 0);
    g_ksr = 1'b0;
    present(9, 1, 15, 11, 15, 15, 0, 0, 0, 0, 0);
    repeat (8) present(9, 1, 15, 11, 15, 15, 0, 0, 0, 0, 0);
    idle(4);

    // slot 3 back to back, reset while the first is at p2
    g_block = 3'd0; g_fnum = 2'b00;
    present(3, 1, 13, 15, 15, 15, 0, 0, 0, 0, 0);
    present(3, 1, 13, 15, 15, 15, 0, 0, 0, 0, 0);
    do_reset();
    idle(4);
    present(3, 0, 13, 15, 15, 15, 0, 0, 0, 0, 0);
    present(2, 0, 15, 15, 15, 0, 0, 0, 0, 0, 0);
    idle(6);

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
